i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
- Standard-I2S serial audio receiver (Philips format, MSB first, one-BCLK data delay after WS edge), clocked by the system master clock.
- Oversamples externally driven bit clock, word select and serial data; deserialises left/right words; emits one parallel stereo sample pair per frame with a single-cycle valid strobe.
- Counterpart of the synth's I2S transmitter. Used for loopback verification of the audio path and as an input path for external codecs.

Parameters:
- SAMPLE_WIDTH, 16, bits kept per channel word, signed two's complement.
- SYNC_STAGES, 2, flip-flop synchroniser depth on i2s_bclk, i2s_ws and i2s_sd (minimum 2).

Ports:
- clk  input  1  master clock; every register is in this domain.
- rst  input  1  synchronous, active-low reset.
- i2s_bclk  input  1  external bit clock, asynchronous to clk; frequency at most clk/4.
- i2s_ws  input  1  word select: 0 = left, 1 = right.
- i2s_sd  input  1  serial data.
- left_sample  output  SAMPLE_WIDTH  last complete left word, signed.
- right_sample  output  SAMPLE_WIDTH  last complete right word, signed.
- sample_valid  output  1  one-clk pulse when a new left/right pair is loaded.
- locked  output  1  high once framing has been acquired.
- frame_error  output  1  one-clk pulse when a slot is shorter than SAMPLE_WIDTH bits.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs go to 0.
  - Synchronisers, shift register, bit counter and held left word are cleared.
  - State goes to HUNT.
  - A reset mid-frame discards any partial word; no sample_valid is produced from pre-reset bits.
- Edge detect:
  - Bits are sampled only on a registered rising edge of synchronised bclk (sync_bclk=1 while the previous value was 0).
  - ws and sd are taken from the same synchroniser stage as bclk, so all three stay aligned.
- Slot boundary: at a sampling edge where sampled ws differs from ws_last:
  - The sd bit on that edge is the final (LSB) bit of the slot that is ending.
  - The ending slot closes after that bit is shifted in.
  - The next sampling edge carries the MSB of the slot selected by the new ws value.
- State machine: HUNT, LEFT, RIGHT.
  - HUNT: ignore data; on the first 1->0 ws transition go to LEFT (locked stays 0).
  - LEFT: shift bits MSB first. At the boundary into ws=1, latch the left word internally and go to RIGHT.
  - RIGHT: shift bits MSB first. At the boundary into ws=0:
    - Load left_sample from the latched word and right_sample from the right word.
    - Pulse sample_valid.
    - Set locked=1.
    - Go to LEFT.
  - A 0->1 ws transition seen in HUNT is ignored.
- Bit counting, saturating at SAMPLE_WIDTH:
  - Bits beyond SAMPLE_WIDTH in a slot are discarded, which supports 32-bit slots carrying 16-bit data.
  - If a slot closes with fewer than SAMPLE_WIDTH bits, the word is left-justified with zero LSBs, frame_error pulses in the same cycle the slot closes, and the frame is still delivered.
  - Counter width is clog2(SAMPLE_WIDTH+1).
- Latency: sample_valid is high exactly SYNC_STAGES+2 clk cycles after the i2s_bclk rising edge at the pin that carries the right-word LSB. left_sample and right_sample change in the same cycle as the pulse and are held until the next pulse.
- Framing loss: if ws does not toggle within 64 sampling edges while in LEFT or RIGHT:
  - Clear locked and return to HUNT.
  - Output samples hold their values; no pulse is generated.
- Simultaneous events: frame_error and sample_valid may assert in the same cycle. Reset has priority over everything.

Optional Feature:
- Macro I2S_RX_ERR_COUNT_EN.
- When defined:
  - Adds output port err_count (8 bits).
  - err_count increments on every frame_error pulse and on every framing-loss event (both in one cycle count as 1).
  - It saturates at 255 and is cleared only by reset.
- When undefined: the port and counter are absent and all other behaviour is identical.

Test Plan:
- Reset, then clean frames with bclk=clk/8, 16-bit slots, left=16'h1234, right=16'hABCD:
  - First frame after HUNT is dropped.
  - Each following frame gives sample_valid with left_sample=1234h, right_sample=ABCDh and locked=1.
  - Pulse occurs SYNC_STAGES+2 clks after the right LSB bclk rise.
- 32-bit slots carrying left=16'h8001 then 16 junk bits, right=16'h7FFF then 16 junk bits: outputs are 8001h and 7FFFh with no frame_error.
- 12-bit right slot with bits A5Bh: right_sample=A5B0h, frame_error pulses in the same cycle as sample_valid, err_count=1 with the macro defined.
- rst driven low for one clk in the middle of a right word: all outputs are 0 and there is no sample_valid until the next full left+right frame after reacquisition.
- ws held at 0 for 80 bclk cycles after lock: locked falls after the 64th sampling edge, samples hold, relock occurs on the next 1->0 ws transition.
- Loopback with the synth's i2s_transmitter sending a sample ramp 0000h, 0001h, 0002h, ... on both channels: the received pairs match the sent sequence with no frame_error.

Source files
------------

// File: rtl/i2s_receiver.sv
// i2s_receiver: Philips-format I2S receiver clocked by the system master clock.
// Bit clock, word select and serial data are oversampled through a shared
// synchroniser. Left/right words are deserialised MSB first, and one stereo
// pair is presented per frame with a one-cycle sample_valid strobe.
// Optional feature macro: I2S_RX_ERR_COUNT_EN adds the 8-bit err_count output.
`timescale 1ns/1ps
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i2s_bclk,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    locked,
  output logic                    frame_error
`ifdef I2S_RX_ERR_COUNT_EN
  ,
  output logic [7:0]              err_count
`endif
);

  localparam int                 CNT_W      = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CNT_W-1:0]   SW_CNT     = CNT_W'(SAMPLE_WIDTH);
  localparam logic [5:0]         IDLE_LIMIT = 6'd63;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic [SYNC_STAGES-1:0]  bclk_sync_r;
  logic [SYNC_STAGES-1:0]  ws_sync_r;
  logic [SYNC_STAGES-1:0]  sd_sync_r;
  logic                    bclk_d_r;
  logic                    rise_r;
  logic                    ws_r;
  logic                    sd_r;
  logic                    ws_last_r;
  logic [1:0]              state_r;
  logic [SAMPLE_WIDTH-1:0] shift_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [5:0]              idle_cnt_r;
  logic [SAMPLE_WIDTH-1:0] left_hold_r;

  logic                    boundary_s;
  logic [SAMPLE_WIDTH-1:0] shift_in_s;
  logic [CNT_W-1:0]        cnt_in_s;
  logic [SAMPLE_WIDTH-1:0] word_s;
  logic                    short_s;
  logic                    in_frame_s;
  logic                    close_err_s;
  logic                    loss_s;

  // Synchronise the three pins together, then register the bclk rising edge
  // alongside the matching ws/sd samples so all three stay aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bclk_sync_r <= '0;
      ws_sync_r   <= '0;
      sd_sync_r   <= '0;
      bclk_d_r    <= 1'b0;
      rise_r      <= 1'b0;
      ws_r        <= 1'b0;
      sd_r        <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], i2s_bclk};
      ws_sync_r   <= {ws_sync_r[SYNC_STAGES-2:0], i2s_ws};
      sd_sync_r   <= {sd_sync_r[SYNC_STAGES-2:0], i2s_sd};
      bclk_d_r    <= bclk_sync_r[SYNC_STAGES-1];
      rise_r      <= bclk_sync_r[SYNC_STAGES-1] & ~bclk_d_r;
      ws_r        <= ws_sync_r[SYNC_STAGES-1];
      sd_r        <= sd_sync_r[SYNC_STAGES-1];
    end
  end

  // Next shift/count values with saturation, plus the left-justified word and
  // the slot-close / framing-loss events for the current sampling edge.
  always_comb begin
    boundary_s = ws_r ^ ws_last_r;
    if (bit_cnt_r < SW_CNT) begin
      shift_in_s = {shift_r[SAMPLE_WIDTH-2:0], sd_r};
      cnt_in_s   = bit_cnt_r + CNT_W'(1);
    end else begin
      shift_in_s = shift_r;
      cnt_in_s   = bit_cnt_r;
    end
    word_s      = shift_in_s << (SW_CNT - cnt_in_s);
    short_s     = (cnt_in_s < SW_CNT);
    in_frame_s  = (state_r == ST_LEFT) || (state_r == ST_RIGHT);
    close_err_s = rise_r && in_frame_s && boundary_s && short_s;
    loss_s      = rise_r && in_frame_s && !boundary_s && (idle_cnt_r == IDLE_LIMIT);
  end

  // Framing state machine, deserialiser and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ws_last_r    <= 1'b0;
      state_r      <= ST_HUNT;
      shift_r      <= '0;
      bit_cnt_r    <= '0;
      idle_cnt_r   <= 6'd0;
      left_hold_r  <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_error  <= close_err_s;
      if (rise_r) begin
        ws_last_r <= ws_r;
        case (state_r)
          ST_HUNT: begin
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            idle_cnt_r <= 6'd0;
            if (boundary_s && !ws_r) begin
              state_r <= ST_LEFT;
            end else begin
              state_r <= ST_HUNT;
            end
          end
          ST_LEFT, ST_RIGHT: begin
            if (boundary_s) begin
              // The boundary bit is the LSB of the closing slot.
              shift_r    <= '0;
              bit_cnt_r  <= '0;
              idle_cnt_r <= 6'd0;
              if (state_r == ST_LEFT) begin
                left_hold_r <= word_s;
                state_r     <= ST_RIGHT;
              end else begin
                left_sample  <= left_hold_r;
                right_sample <= word_s;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                state_r      <= ST_LEFT;
              end
            end else if (loss_s) begin
              // ws stopped toggling: drop the partial word and re-hunt.
              shift_r    <= '0;
              bit_cnt_r  <= '0;
              idle_cnt_r <= 6'd0;
              locked     <= 1'b0;
              state_r    <= ST_HUNT;
            end else begin
              shift_r    <= shift_in_s;
              bit_cnt_r  <= cnt_in_s;
              idle_cnt_r <= idle_cnt_r + 6'd1;
            end
          end
          default: begin
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            idle_cnt_r <= 6'd0;
            locked     <= 1'b0;
            state_r    <= ST_HUNT;
          end
        endcase
      end
    end
  end

`ifdef I2S_RX_ERR_COUNT_EN
  // Saturating count of short slots and framing-loss events.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count <= 8'd0;
    end else if ((close_err_s || loss_s) && (err_count != 8'd255)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives I2S frames (bclk = clk/8) into i2s_receiver and
// compares each delivered pair against a transaction-level model of the
// framing rules. Compile with I2S_RX_ERR_COUNT_EN to also cover err_count.
`timescale 1ns/1ps
module tb_i2s_receiver;
  localparam int SW   = 16;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i2s_bclk = 1'b0;
  logic i2s_ws = 1'b0;
  logic i2s_sd = 1'b0;
  logic [SW-1:0] left_sample;
  logic [SW-1:0] right_sample;
  logic sample_valid;
  logic locked;
  logic frame_error;
`ifdef I2S_RX_ERR_COUNT_EN
  logic [7:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int n_pulse = 0;
  int fe_seen = 0;
  int exp_fe = 0;
  int model_err = 0;
  bit aligned = 1'b0;
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];
  logic        exp_short[$];
  logic [15:0] last_l = 16'h0000;
  logic [15:0] last_r = 16'h0000;

  always #5 clk = ~clk;

  i2s_receiver #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .locked(locked), .frame_error(frame_error)
`ifdef I2S_RX_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word kept by the receiver from an n-bit MSB-first slot carrying v.
  function automatic logic [15:0] exp_word(input logic [31:0] v, input int n);
    if (n >= SW) return 16'(v >> (n - SW));
    else return 16'(v << (SW - n));
  endfunction

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every sample_valid must match the next expected pair.
  always @(posedge clk) begin
    #1;
    if (sample_valid === 1'b1) begin
      n_pulse++;
      check_eq("valid_expected", 32'(exp_l.size() > 0), 32'd1);
      if (exp_l.size() > 0) begin
        check_eq("left_sample", 32'(left_sample), 32'(exp_l.pop_front()));
        check_eq("right_sample", 32'(right_sample), 32'(exp_r.pop_front()));
        check_eq("fe_with_valid", 32'(frame_error), 32'(exp_short.pop_front()));
        check_eq("locked_at_valid", 32'(locked), 32'd1);
        check_eq("latency", 32'(cyc - last_rise_cyc), 32'(SYNC + 2));
      end
    end
    if (frame_error === 1'b1) fe_seen++;
  end

  // One bclk period: low half with new ws/sd, optional reset pulse, high half.
  task automatic drive_bit(input logic ws, input logic sd, input bit do_rst);
    i2s_bclk = 1'b0;
    i2s_ws   = ws;
    i2s_sd   = sd;
    if (do_rst) begin
      #15 rst = 1'b0;
      #10 rst = 1'b1;
      #15;
    end else begin
      #40;
    end
    i2s_bclk = 1'b1;
    last_rise_cyc = cyc;
    #40;
  endtask

  // One frame in Philips timing: ws switches on the LSB of each slot.
  task automatic send_frame(input logic [31:0] lv, input int lw,
                            input logic [31:0] rv, input int rw, input int rst_idx);
    bit deliver;
    deliver = aligned && (rst_idx < 0);
    for (int j = 0; j < lw; j++) drive_bit(j == lw - 1, lv[lw-1-j], 1'b0);
    if (deliver) begin
      exp_l.push_back(exp_word(lv, lw));
      exp_r.push_back(exp_word(rv, rw));
      exp_short.push_back(rw < SW);
      last_l = exp_word(lv, lw);
      last_r = exp_word(rv, rw);
      exp_fe    += int'(lw < SW) + int'(rw < SW);
      model_err += int'(lw < SW) + int'(rw < SW);
      if (model_err > 255) model_err = 255;
    end
    for (int j = 0; j < rw; j++) drive_bit(j != rw - 1, rv[rw-1-j], j == rst_idx);
    if (rst_idx >= 0) model_err = 0;
    aligned = 1'b1;
  endtask

  task automatic check_err_count(input string tag);
`ifdef I2S_RX_ERR_COUNT_EN
    check_eq(tag, 32'(err_count), 32'(model_err));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lv;
    logic [31:0] rv;
    int lw;
    int rw;
    // Reset with pins idle.
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    check_eq("rst_left", 32'(left_sample), 32'd0);
    check_eq("rst_right", 32'(right_sample), 32'd0);
    check_eq("rst_valid", 32'(sample_valid), 32'd0);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_frame_error", 32'(frame_error), 32'd0);
    check_err_count("rst_err_count");

    // Clean 16-bit frames: the first is consumed by acquisition.
    send_frame(32'h1234, 16, 32'hABCD, 16, -1);
    check_eq("first_frame_dropped", 32'(n_pulse), 32'd0);
    check_eq("locked_after_hunt", 32'(locked), 32'd0);
    for (int k = 0; k < 3; k++) send_frame(32'h1234, 16, 32'hABCD, 16, -1);
    check_eq("locked_clean", 32'(locked), 32'd1);
    check_eq("clean_pulses", 32'(n_pulse), 32'd3);

    // 32-bit slots carrying 16-bit data plus junk.
    for (int k = 0; k < 2; k++) begin
      lv = {16'h8001, 16'($urandom)};
      rv = {16'h7FFF, 16'($urandom)};
      send_frame(lv, 32, rv, 32, -1);
    end
    check_eq("hold_left_32", 32'(left_sample), 32'h8001);
    check_eq("hold_right_32", 32'(right_sample), 32'h7FFF);
    check_eq("fe_count_32", 32'(fe_seen), 32'd0);

    // Short 12-bit right slot.
    send_frame(32'h1234, 16, 32'h0A5B, 12, -1);
    check_eq("short_right", 32'(right_sample), 32'hA5B0);
    check_err_count("err_count_short");

    // Randomised slot widths and data.
    for (int k = 0; k < 20; k++) begin
      lw = $urandom_range(8, 32);
      rw = $urandom_range(8, 32);
      lv = $urandom;
      rv = $urandom;
      send_frame(lv, lw, rv, rw, -1);
    end
    check_err_count("err_count_random");

    // Reset in the middle of a right word.
    send_frame(32'h5555, 16, 32'hAAAA, 16, 7);
    check_eq("midrst_left", 32'(left_sample), 32'd0);
    check_eq("midrst_right", 32'(right_sample), 32'd0);
    check_eq("midrst_locked", 32'(locked), 32'd0);
    check_err_count("midrst_err_count");
    send_frame(32'h1357, 16, 32'h2468, 16, -1);
    send_frame(32'h0F0F, 16, 32'hF0F0, 16, -1);
    check_eq("relock_after_rst", 32'(locked), 32'd1);

    // ws stuck low: framing loss on the 64th sampling edge.
    for (int j = 0; j < 63; j++) drive_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check_eq("locked_edge63", 32'(locked), 32'd1);
    drive_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    check_eq("locked_edge64", 32'(locked), 32'd0);
    check_eq("loss_hold_left", 32'(left_sample), 32'(last_l));
    check_eq("loss_hold_right", 32'(right_sample), 32'(last_r));
    model_err = (model_err < 255) ? model_err + 1 : 255;
    aligned = 1'b0;
    check_err_count("err_count_loss");
    for (int j = 0; j < 16; j++) drive_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Ramp as produced by the transmitter; first frame re-acquires.
    send_frame(32'hFFFF, 16, 32'hFFFF, 16, -1);
    for (int k = 0; k < 16; k++) send_frame(32'(k), 16, 32'(k), 16, -1);
    check_eq("ramp_locked", 32'(locked), 32'd1);
    check_eq("ramp_last_left", 32'(left_sample), 32'd15);

    repeat (8) @(posedge clk);
    #2;
    check_eq("pending_pairs", 32'(exp_l.size()), 32'd0);
    check_eq("frame_error_total", 32'(fe_seen), 32'(exp_fe));
    check_err_count("err_count_final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
